rv_multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the RV32I-subset core. It sequences instruction fetch, decode, execute, data-memory access and writeback.
- Drives the register-enable and mux-select strobes of the datapath around the instruction register, immediate generator, ALU, register file and PC.
- Classifies each instruction from the instruction-register output. Opcodes and OP-IMM funct3 values that the immediate generator does not cover are trapped.
- Also counts retired instructions and detects memory handshake timeouts.

---
 rtl/rv_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Multicycle control FSM for the RV32I-subset core. It walks each instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
// enables and mux selects around the IR, immediate generator, ALU, register
// file and PC. It also counts retired instructions and traps on illegal
// opcodes and on memory handshake timeouts.
//
// Handshake: a request (imem_req / dmem_req) is held high in its state until
// the matching ack is seen in the same cycle. The ack completes the transfer
// in that cycle. Requests never drop without an ack, except on reset or trap.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   inst_code[31:0]    instruction register output
//   imem_ack           instruction word valid this cycle
//   dmem_ack           data access complete this cycle
//   branch_taken       ALU compare result for the current branch
//   imem_req, ir_we    fetch request / IR load enable (ir_we = imem_ack in FETCH)
//   dmem_req, dmem_we  data request; 1 = store, 0 = load
//   alu_src_b          0 = rs2, 1 = immediate
//   alu_op[1:0]        00 add, 01 branch compare, 10 funct3/funct7 decoded
//   reg_we, wb_sel     register write enable; 00 ALU, 01 mem, 10 PC+4, 11 imm
//   pc_we, pc_src      PC write enable; 0 = PC+4, 1 = PC+imm
//   retire             one-cycle pulse per completed instruction
//   instret            retired-instruction count (wraps)
//   trap, trap_cause   sticky fault; 01 illegal, 10 imem timeout, 11 dmem timeout
//   state_o[2:0]       FSM state for debug/checkers
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_code,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic             pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD   = 3'd0,
        C_OPIMM  = 3'd1,
        C_STORE  = 3'd2,
        C_BRANCH = 3'd3,
        C_JAL    = 3'd4,
        C_LUI    = 3'd5,
        C_OP     = 3'd6
    } class_t;

    // Wait counter only needs to reach ACK_TIMEOUT.
    localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT);

    state_t            state, state_next;
    class_t            cls, dec_class;
    logic              dec_legal;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              ack_seen;
    logic [1:0]        cause_next;

    assign state_o = state;

    // A zero limit disables the timeout entirely.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);
    assign ack_seen    = ((state == S_FETCH) && imem_ack) ||
                         ((state == S_MEM)   && dmem_ack);

    // Instruction classification; only meaningful while in DECODE.
    always_comb begin
        dec_class = C_OP;
        dec_legal = 1'b1;
        case (inst_code[6:0])
            7'b0000011: dec_class = C_LOAD;
            7'b0010011: begin
                dec_class = C_OPIMM;
                // The immediate generator only handles ADDI, SLTI, SLLI, SRLI/SRAI.
                dec_legal = (inst_code[14:12] == 3'b000) || (inst_code[14:12] == 3'b010) ||
                            (inst_code[14:12] == 3'b001) || (inst_code[14:12] == 3'b101);
            end
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
            7'b1101111: dec_class = C_JAL;
            7'b0110111: dec_class = C_LUI;
            7'b0110011: dec_class = C_OP;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_next = state;
        cause_next = 2'b00;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        reg_we     = 1'b0;
        wb_sel     = 2'b00;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
                if (imem_ack) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    cause_next = 2'b10;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    cause_next = 2'b01;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_OP: begin
                        alu_op     = 2'b10;
                        state_next = S_WB;
                    end
                    C_OPIMM: begin
                        alu_src_b  = 1'b1;
                        alu_op     = 2'b10;
                        state_next = S_WB;
                    end
                    C_LUI: state_next = S_WB;
                    C_LOAD, C_STORE: begin
                        alu_src_b  = 1'b1;
                        state_next = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op     = 2'b01;
                        pc_we      = 1'b1;
                        pc_src     = branch_taken;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    C_JAL: begin
                        reg_we     = 1'b1;
                        wb_sel     = 2'b10;
                        pc_we      = 1'b1;
                        pc_src     = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Address computation stays selected while the access is pending.
                dmem_req  = 1'b1;
                dmem_we   = (cls == C_STORE);
                alu_src_b = 1'b1;
                if (dmem_ack) begin
                    if (cls == C_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    cause_next = 2'b11;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
                if (cls == C_LUI) begin
                    wb_sel = 2'b11;
                end else if (cls == C_LOAD) begin
                    wb_sel = 2'b01;
                end
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase

        // The state register only clears at the edge, so silence the
        // datapath for the whole cycle in which reset is held.
        if (reset) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            alu_src_b = 1'b0;
            alu_op    = 2'b00;
            reg_we    = 1'b0;
            wb_sel    = 2'b00;
            pc_we     = 1'b0;
            pc_src    = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            cls        <= C_LOAD;
            wait_cnt   <= '0;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state <= state_next;

            if (state == S_DECODE) begin
                cls <= dec_class;
            end

            if ((state_next != state) || ack_seen) begin
                wait_cnt <= '0;
            end else if ((state == S_FETCH) || (state == S_MEM)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (retire) begin
                instret <= instret + CNT_W'(1);
            end

            if ((state_next == S_TRAP) && (state != S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= cause_next;
            end
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, well before the next rising edge.
// Observed vector layout (16 bits):
//   state[2:0] _ imem_req,ir_we _ dmem_req,dmem_we _ alu_src_b,alu_op[1:0]
//   _ reg_we,wb_sel[1:0] _ pc_we,pc_src,retire
module tb_rv_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      inst_code;
  logic             imem_ack;
  logic             dmem_ack;
  logic             branch_taken;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             pc_we;
  logic             pc_src;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state_o;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.CNT_W(CNT_W), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .inst_code(inst_code),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_src(pc_src), .retire(retire), .instret(instret),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  logic [15:0] obs;
  assign obs = {state_o, imem_req, ir_we, dmem_req, dmem_we, alu_src_b, alu_op,
                reg_we, wb_sel, pc_we, pc_src, retire};

  localparam logic [15:0] V_FETCH_ACK  = 16'b000_11_00_000_000_000;
  localparam logic [15:0] V_FETCH_WAIT = 16'b000_10_00_000_000_000;
  localparam logic [15:0] V_DECODE     = 16'b001_00_00_000_000_000;
  localparam logic [15:0] V_TRAP       = 16'b111_00_00_000_000_000;
  localparam logic [15:0] V_EX_MEM     = 16'b010_00_00_100_000_000;
  localparam logic [15:0] V_LW_WAIT    = 16'b011_00_10_100_000_000;
  localparam logic [15:0] V_BEQ_NT     = 16'b010_00_00_001_000_101;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One clock cycle: drive inputs at the falling edge, then check outputs.
  task automatic cyc(input logic ia, input logic da, input logic bt,
                     input logic [15:0] exp, input string tag);
    @(negedge clk);
    reset        = 1'b0;
    imem_ack     = ia;
    dmem_ack     = da;
    branch_taken = bt;
    #1;
    check(tag, 32'(obs), 32'(exp));
  endtask

  // Two reset cycles; strobes must be silent in both.
  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset        = 1'b1;
      imem_ack     = 1'b0;
      dmem_ack     = 1'b0;
      branch_taken = 1'b0;
      #1;
      check("reset_strobes", 32'(obs[12:0]), 32'd0);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp);
    @(posedge clk);
    #1;
    check(tag, 32'(instret), 32'(exp));
  endtask

  task automatic run_beq(input logic bt, input logic [15:0] exec_exp);
    inst_code = 32'h00208463;
    cyc(1, 0, 0, V_FETCH_ACK, "beq_fetch");
    cyc(0, 0, 0, V_DECODE, "beq_decode");
    cyc(0, 0, bt, exec_exp, "beq_exec");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
    inst_code = 32'h0;
    do_reset();
    check("reset_instret", 32'(instret), 32'd0);
    check("reset_trap", {30'd0, trap_cause}, 32'd0);

    // ADDI x1,x0,5
    inst_code = 32'h00500093;
    cyc(1, 0, 0, V_FETCH_ACK, "addi_fetch");
    cyc(0, 0, 0, V_DECODE, "addi_decode");
    cyc(0, 0, 0, 16'b010_00_00_110_000_000, "addi_exec");
    cyc(0, 0, 0, 16'b100_00_00_000_100_101, "addi_wb");
    check_cnt("addi_instret", 4'd1);

    // LW, dmem_ack after 3 wait cycles
    inst_code = 32'h0000A103;
    cyc(1, 0, 0, V_FETCH_ACK, "lw_fetch");
    cyc(0, 0, 0, V_DECODE, "lw_decode");
    cyc(0, 0, 0, V_EX_MEM, "lw_exec");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, V_LW_WAIT, "lw_mem_wait");
    cyc(0, 1, 0, V_LW_WAIT, "lw_mem_ack");
    cyc(0, 0, 0, 16'b100_00_00_000_101_101, "lw_wb");
    cyc(0, 0, 0, V_FETCH_WAIT, "lw_next_fetch");
    check("lw_instret", 32'(instret), 32'd2);

    // BEQ taken then not taken
    run_beq(1'b1, 16'b010_00_00_001_000_111);
    run_beq(1'b0, V_BEQ_NT);
    check_cnt("beq_instret", 4'd4);

    // SW with one wait cycle; no WB state
    inst_code = 32'h0020A223;
    cyc(1, 0, 0, V_FETCH_ACK, "sw_fetch");
    cyc(0, 0, 0, V_DECODE, "sw_decode");
    cyc(0, 0, 0, V_EX_MEM, "sw_exec");
    cyc(0, 0, 0, 16'b011_00_11_100_000_000, "sw_mem_wait");
    cyc(0, 1, 0, 16'b011_00_11_100_000_101, "sw_mem_ack");
    cyc(0, 0, 0, V_FETCH_WAIT, "sw_next_fetch");

    // JAL
    inst_code = 32'h008000EF;
    cyc(1, 0, 0, V_FETCH_ACK, "jal_fetch");
    cyc(0, 0, 0, V_DECODE, "jal_decode");
    cyc(0, 0, 0, 16'b010_00_00_000_110_111, "jal_exec");

    // LUI
    inst_code = 32'h123450B7;
    cyc(1, 0, 0, V_FETCH_ACK, "lui_fetch");
    cyc(0, 0, 0, V_DECODE, "lui_decode");
    cyc(0, 0, 0, 16'b010_00_00_000_000_000, "lui_exec");
    cyc(0, 0, 0, 16'b100_00_00_000_111_101, "lui_wb");

    // ADD (OP)
    inst_code = 32'h002081B3;
    cyc(1, 0, 0, V_FETCH_ACK, "op_fetch");
    cyc(0, 0, 0, V_DECODE, "op_decode");
    cyc(0, 0, 0, 16'b010_00_00_010_000_000, "op_exec");
    cyc(0, 0, 0, 16'b100_00_00_000_100_101, "op_wb");
    check_cnt("mix_instret", 4'd8);

    // Reset in the middle of a load: abandoned, no retire
    inst_code = 32'h0000A103;
    cyc(1, 0, 0, V_FETCH_ACK, "abort_fetch");
    cyc(0, 0, 0, V_DECODE, "abort_decode");
    cyc(0, 0, 0, V_EX_MEM, "abort_exec");
    cyc(0, 0, 0, V_LW_WAIT, "abort_mem");
    do_reset();
    cyc(0, 0, 0, V_FETCH_WAIT, "abort_after_reset");
    check("abort_instret", 32'(instret), 32'd0);

    // instret wraps 15 -> 0
    do_reset();
    for (int i = 0; i < 15; i++) run_beq(1'b0, V_BEQ_NT);
    check_cnt("wrap_15", 4'd15);
    run_beq(1'b0, V_BEQ_NT);
    check_cnt("wrap_0", 4'd0);

    // JALR is illegal
    inst_code = 32'h000080E7;
    cyc(1, 0, 0, V_FETCH_ACK, "jalr_fetch");
    cyc(0, 0, 0, V_DECODE, "jalr_decode");
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, V_TRAP, "jalr_trap_hold");
    check("jalr_trap", {31'd0, trap}, 32'd1);
    check("jalr_cause", {30'd0, trap_cause}, 32'd1);
    check("jalr_instret", 32'(instret), 32'd0);

    // OP-IMM funct3=011 is illegal
    do_reset();
    inst_code = 32'h00503093;
    cyc(1, 0, 0, V_FETCH_ACK, "sltiu_fetch");
    cyc(0, 0, 0, V_DECODE, "sltiu_decode");
    cyc(0, 0, 0, V_TRAP, "sltiu_trap");
    check("sltiu_trap", {31'd0, trap}, 32'd1);
    check("sltiu_cause", {30'd0, trap_cause}, 32'd1);

    // imem timeout: 5 unacked FETCH cycles then TRAP cause 10
    do_reset();
    inst_code = 32'h00500093;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, V_FETCH_WAIT, "ito_wait");
    cyc(0, 0, 0, V_TRAP, "ito_trap");
    check("ito_cause", {30'd0, trap_cause}, 32'd2);

    // Reset during TRAP clears it; ack on 5th cycle wins over the limit
    do_reset();
    cyc(0, 0, 0, V_FETCH_WAIT, "ito_rst_fetch");
    check("ito_rst_trap", {31'd0, trap}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, V_FETCH_WAIT, "ilim_wait");
    cyc(1, 0, 0, V_FETCH_ACK, "ilim_ack");
    cyc(0, 0, 0, V_DECODE, "ilim_decode");

    // dmem timeout: 5 unacked MEM cycles then TRAP cause 11
    do_reset();
    inst_code = 32'h0000A103;
    cyc(1, 0, 0, V_FETCH_ACK, "dto_fetch");
    cyc(0, 0, 0, V_DECODE, "dto_decode");
    cyc(0, 0, 0, V_EX_MEM, "dto_exec");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, V_LW_WAIT, "dto_wait");
    cyc(0, 0, 0, V_TRAP, "dto_trap");
    check("dto_cause", {30'd0, trap_cause}, 32'd3);
    check("dto_instret", 32'(instret), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
